// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared definitions for the sequential right shifter: default
//               widths, MODE encodings and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SHW   = 3;

  // Operation select; 2'b11 decodes as rotate as well.
  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shr_step.sv
`default_nettype none
// ============================================================================
// Module      : shr_step
// Description : Combinational single-position right shift / rotate.
// Ports       : data    - word to shift
//               mode    - 00 logical, 01 arithmetic, 1x rotate
//               shifted - data moved right by one position
// Revision    : 1.0 - initial release
// ============================================================================
module shr_step
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] shifted
);

  always_comb begin
    shifted = {1'b0, data[WIDTH-1:1]};
    case (mode)
      MODE_LSR: shifted = {1'b0, data[WIDTH-1:1]};
      MODE_ASR: shifted = {data[WIDTH-1], data[WIDTH-1:1]};
      default:  shifted = {data[0], data[WIDTH-1:1]};  // rotate (10 and 11)
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seq_right_shifter.sv
`default_nettype none
// ============================================================================
// Module      : seq_right_shifter
// Description : Multi-cycle right shifter/rotator, one bit position per clock,
//               with a START/DONE handshake. Inverse companion of the left
//               barrel shifter.
// Ports       : clk    - rising-edge clock
//               rst    - asynchronous active-high reset
//               START  - request, sampled at clk rising edge
//               NUM    - operand, captured on accepted START
//               SEL    - shift amount, captured on accepted START
//               MODE   - 00 LSR, 01 ASR, 1x rotate right
//               BUSY   - high while an operation is in progress
//               DONE   - one-cycle pulse when NUMOUT is updated
//               NUMOUT - result, held until the next completion
// Revision    : 1.0 - initial release
// ============================================================================
module seq_right_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             START,
  input  logic [WIDTH-1:0] NUM,
  input  logic [SHW-1:0]   SEL,
  input  logic [1:0]       MODE,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] NUMOUT
);

  state_t           state;
  logic [WIDTH-1:0] data_r;
  logic [SHW-1:0]   cnt;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] step_data;

  shr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data    (data_r),
    .mode    (mode_r),
    .shifted (step_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      data_r <= '0;
      cnt    <= '0;
      mode_r <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      NUMOUT <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        // The completion cycle accepts a new request exactly like IDLE,
        // which allows back-to-back operations without a dead cycle.
        ST_IDLE, ST_DONE: begin
          if (START) begin
            data_r <= NUM;
            cnt    <= SEL;
            mode_r <= MODE;
            BUSY   <= 1'b1;
            state  <= ST_SHIFT;
          end else begin
            state  <= ST_IDLE;
          end
        end
        // START and input changes are deliberately ignored here.
        ST_SHIFT: begin
          if (cnt != '0) begin
            data_r <= step_data;
            cnt    <= cnt - 1'b1;
          end else begin
            NUMOUT <= data_r;
            DONE   <= 1'b1;
            BUSY   <= 1'b0;
            state  <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_right_shifter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_seq_right_shifter
// Description : Self-checking bench for seq_right_shifter. A cycle-level
//               behavioural model (result from plain arithmetic, completion
//               due SEL+1 cycles after acceptance) is compared every cycle,
//               alongside directed vectors with literal expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_right_shifter;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       START = 1'b0;
  logic [7:0] NUM   = 8'h00;
  logic [2:0] SEL   = 3'd0;
  logic [1:0] MODE  = 2'b00;
  logic       BUSY;
  logic       DONE;
  logic [7:0] NUMOUT;

  int vecs     = 0;
  int errs     = 0;
  int done_cnt = 0;

  seq_right_shifter #(.WIDTH(8), .SHW(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .START  (START),
    .NUM    (NUM),
    .SEL    (SEL),
    .MODE   (MODE),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .NUMOUT (NUMOUT)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the operation definitions.
  function automatic logic [7:0] ref_res(input logic [7:0] n, input int s, input logic [1:0] m);
    logic [15:0] d;
    case (m)
      2'b00:   return n >> s;
      2'b01:   return 8'($signed(n) >>> s);
      default: begin
        d = {n, n} >> s;
        return d[7:0];
      end
    endcase
  endfunction

  // Left rotate, as performed by the companion barrel shifter.
  function automatic logic [7:0] bs_rol(input logic [7:0] n, input int s);
    logic [15:0] d;
    d = {n, n} << s;
    return d[15:8];
  endfunction

  // Behavioural model: an operation is pending for SEL+1 edges after accept.
  logic       m_busy, m_done;
  logic [7:0] m_out, m_res;
  int         m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_out  = 8'h00;
      m_res  = 8'h00;
      m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (m_left == 0) begin
          m_out  = m_res;
          m_done = 1'b1;
          m_busy = 1'b0;
        end else begin
          m_left--;
        end
      end else if (START) begin
        m_res  = ref_res(NUM, int'(SEL), MODE);
        m_left = int'(SEL);
        m_busy = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy",   {7'b0, BUSY}, {7'b0, m_busy});
      check("done",   {7'b0, DONE}, {7'b0, m_done});
      check("numout", NUMOUT, m_out);
      if (DONE) done_cnt++;
    end
  end

  // Called at a negedge; presents one request for one clock edge.
  task automatic op(input logic [7:0] n, input logic [2:0] s, input logic [1:0] m);
    NUM   = n;
    SEL   = s;
    MODE  = m;
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
  endtask

  // Waits (bounded) for DONE; k is the number of negedges waited.
  task automatic wait_done(input string name, input logic [7:0] exp, output int k);
    k = 0;
    while (!DONE && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!DONE) begin
      check({name, "_timeout"}, 8'h00, 8'h01);
    end else begin
      check(name, NUMOUT, exp);
    end
  endtask

  int k;
  int snap;

  initial begin
    #2;
    check("rst_busy",   {7'b0, BUSY}, 8'h00);
    check("rst_done",   {7'b0, DONE}, 8'h00);
    check("rst_numout", NUMOUT, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Logical right by 7
    op(8'b11011010, 3'd7, 2'b00);
    wait_done("lsr7", 8'b00000001, k);
    check("lsr7_lat", 8'(k), 8'd8);
    @(negedge clk);

    // Arithmetic right by 7
    op(8'b11011010, 3'd7, 2'b01);
    wait_done("asr7", 8'b11111111, k);
    check("asr7_lat", 8'(k), 8'd8);
    @(negedge clk);

    // Rotate right by 3, then undo with a left rotate
    op(8'b11011010, 3'd3, 2'b10);
    wait_done("ror3", 8'b01011011, k);
    check("ror3_lat", 8'(k), 8'd4);
    check("roundtrip", bs_rol(NUMOUT, 3), 8'b11011010);
    @(negedge clk);

    // MODE 11 also rotates
    op(8'b11011010, 3'd1, 2'b11);
    wait_done("ror1_m11", 8'h6D, k);
    @(negedge clk);

    // Zero shift, then back-to-back request during the DONE cycle
    op(8'hA5, 3'd0, 2'b00);
    wait_done("sel0", 8'hA5, k);
    check("sel0_lat", 8'(k), 8'd1);
    op(8'h80, 3'd1, 2'b01);
    wait_done("b2b_asr1", 8'hC0, k);
    check("b2b_lat", 8'(k), 8'd2);
    @(negedge clk);

    // START during SHIFT is ignored
    snap = done_cnt;
    op(8'h3C, 3'd5, 2'b00);
    NUM = 8'hFF; SEL = 3'd1; MODE = 2'b01; START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    wait_done("ignored_start", 8'h01, k);
    repeat (12) @(negedge clk);
    check("one_done_pulse", 8'(done_cnt - snap), 8'd1);

    // Asynchronous reset mid-operation
    op(8'hDA, 3'd7, 2'b00);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",   {7'b0, BUSY}, 8'h00);
    check("arst_done",   {7'b0, DONE}, 8'h00);
    check("arst_numout", NUMOUT, 8'h00);
    @(negedge clk);
    rst  = 1'b0;
    snap = done_cnt;
    repeat (12) @(negedge clk);
    check("no_done_after_rst", 8'(done_cnt - snap), 8'd0);

    // First operation after reset behaves normally
    op(8'hDA, 3'd3, 2'b10);
    wait_done("post_rst_ror3", 8'h5B, k);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
